// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: register enables/clears,
// multi-cycle DM handshake FSM, debug halt and perf counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [4:0]    ex_rd,
  input  logic          ex_is_load,
  input  logic          ex_br_taken,
  input  logic          mem_dm_req,
  input  logic          dm_ready,
  input  logic          halt_req,
  output logic          pc_wen,
  output logic          if_id_wen,
  output logic          if_id_clear,
  output logic          id_ex_wen,
  output logic          id_ex_clear,
  output logic          ex_mem_wen,
  output logic          ex_mem_clear,
  output logic          mem_wb_wen,
  output logic          mem_wb_clear,
  output logic          dm_start,
  output logic [1:0]    state,
  output logic          dm_err,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_DONE = 2'b10,
    HALT     = 2'b11
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [WW-1:0] wcnt;
  logic          tmo;
  logic          lu;
  logic          mstall;
  logic          br_flush;

  assign state = st;
  assign tmo   = (st == MEM_WAIT) && (wcnt == LAST);

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mstall = ((st == RUN) && mem_dm_req) || (st == MEM_WAIT);

  assign br_flush = !rst && (st != HALT) && !mstall && ex_br_taken;

  assign dm_start = !rst && (st == RUN) && mem_dm_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      wcnt      <= '0;
      dm_err    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      st <= nxt;
      if (st == MEM_WAIT)
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
      if (tmo && !dm_ready)
        dm_err <= 1'b1;
      if (!pc_wen && (stall_cnt != {CW{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (br_flush && (flush_cnt != {CW{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      RUN: begin
        if (mem_dm_req)
          nxt = MEM_WAIT;
        else if (halt_req)
          nxt = HALT;
      end
      MEM_WAIT: begin
        if (dm_ready || tmo)
          nxt = MEM_DONE;
      end
      MEM_DONE: nxt = RUN;
      HALT: begin
        if (!halt_req)
          nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  // First matching condition wins: reset, halt, memory stall, branch, hazard.
  always_comb begin
    pc_wen       = 1'b0;
    if_id_wen    = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_wen    = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_wen   = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_wen   = 1'b0;
    mem_wb_clear = 1'b0;
    priority case (1'b1)
      rst: ;
      (st == HALT): ;
      mstall: begin
        mem_wb_wen   = 1'b1;
        mem_wb_clear = 1'b1;
      end
      ex_br_taken: begin
        pc_wen      = 1'b1;
        if_id_wen   = 1'b1;
        if_id_clear = 1'b1;
        id_ex_wen   = 1'b1;
        id_ex_clear = 1'b1;
        ex_mem_wen  = 1'b1;
        mem_wb_wen  = 1'b1;
      end
      lu: begin
        id_ex_wen   = 1'b1;
        id_ex_clear = 1'b1;
        ex_mem_wen  = 1'b1;
        mem_wb_wen  = 1'b1;
      end
      default: begin
        pc_wen     = 1'b1;
        if_id_wen  = 1'b1;
        id_ex_wen  = 1'b1;
        ex_mem_wen = 1'b1;
        mem_wb_wen = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branches, DM handshake,
// timeout, halt and counter saturation.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;

  localparam logic [8:0] C_RUN = 9'b1_10_10_10_10;
  localparam logic [8:0] C_FRZ = 9'b0_00_00_00_00;
  localparam logic [8:0] C_MEM = 9'b0_00_00_00_11;
  localparam logic [8:0] C_BR  = 9'b1_11_11_10_10;
  localparam logic [8:0] C_LU  = 9'b0_00_11_10_10;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          ex_is_load, ex_br_taken;
  logic          mem_dm_req, dm_ready, halt_req;
  logic          pc_wen;
  logic          if_id_wen, if_id_clear;
  logic          id_ex_wen, id_ex_clear;
  logic          ex_mem_wen, ex_mem_clear;
  logic          mem_wb_wen, mem_wb_clear;
  logic          dm_start;
  logic [1:0]    state;
  logic          dm_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0]    ctl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_br_taken  (ex_br_taken),
    .mem_dm_req   (mem_dm_req),
    .dm_ready     (dm_ready),
    .halt_req     (halt_req),
    .pc_wen       (pc_wen),
    .if_id_wen    (if_id_wen),
    .if_id_clear  (if_id_clear),
    .id_ex_wen    (id_ex_wen),
    .id_ex_clear  (id_ex_clear),
    .ex_mem_wen   (ex_mem_wen),
    .ex_mem_clear (ex_mem_clear),
    .mem_wb_wen   (mem_wb_wen),
    .mem_wb_clear (mem_wb_clear),
    .dm_start     (dm_start),
    .state        (state),
    .dm_err       (dm_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign ctl = {pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear,
                ex_mem_wen, ex_mem_clear, mem_wb_wen, mem_wb_clear};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    ex_rd       = 5'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_is_load  = 1'b0;
    ex_br_taken = 1'b0;
    mem_dm_req  = 1'b0;
    dm_ready    = 1'b0;
    halt_req    = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_FRZ));
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] es [8];
    logic [8:0] ec [8];
    logic       ee [7];
    int         pulses;

    idle();
    rst = 1'b1;
    mem_dm_req = 1'b1;
    #1;
    chk("rst_ctl0", 32'(ctl), 32'(C_FRZ));
    chk("rst_dms", 32'(dm_start), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    mem_dm_req = 1'b0;
    #1;
    chk("idle_st", 32'(state), 32'd0);
    chk("idle_ctl", 32'(ctl), 32'(C_RUN));
    chk("idle_stc", 32'(stall_cnt), 32'd0);
    chk("idle_flc", 32'(flush_cnt), 32'd0);
    chk("idle_err", 32'(dm_err), 32'd0);

    // load-use on rs2
    ex_is_load = 1'b1;
    ex_rd      = 5'd5;
    id_rs2     = 5'd5;
    id_use_rs2 = 1'b1;
    #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_stc", 32'(stall_cnt), 32'd1);
    ex_rd  = 5'd0;
    id_rs2 = 5'd0;
    #1;
    chk("lu_x0", 32'(ctl), 32'(C_RUN));
    ex_rd      = 5'd7;
    id_rs1     = 5'd7;
    id_use_rs2 = 1'b0;
    #1;
    chk("lu_nouse", 32'(ctl), 32'(C_RUN));
    id_use_rs1 = 1'b1;
    #1;
    chk("lu_rs1", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_stc2", 32'(stall_cnt), 32'd2);

    // branch outranks load-use
    ex_rd       = 5'd5;
    id_rs2      = 5'd5;
    id_use_rs2  = 1'b1;
    ex_br_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_flc", 32'(flush_cnt), 32'd1);
    chk("br_stc", 32'(stall_cnt), 32'd2);

    // DM access, ready 3 cycles after start, branch held during stall
    do_reset();
    es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    ec = '{C_MEM, C_MEM, C_MEM, C_MEM, C_BR, C_RUN, C_RUN, C_RUN};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      mem_dm_req  = (i < 4);
      dm_ready    = (i == 3);
      ex_br_taken = (i == 1) || (i == 4);
      #1;
      chk($sformatf("mem_st%0d", i), 32'(state), 32'(es[i]));
      chk($sformatf("mem_ctl%0d", i), 32'(ctl), 32'(ec[i]));
      chk($sformatf("mem_dms%0d", i), 32'(dm_start), 32'(i == 0));
      if (dm_start) pulses++;
      tick();
    end
    idle();
    chk("mem_pulses", 32'(pulses), 32'd1);
    chk("mem_stc", 32'(stall_cnt), 32'd4);
    chk("mem_flc", 32'(flush_cnt), 32'd1);
    chk("mem_err", 32'(dm_err), 32'd0);

    // timeout: MEM_WAIT lasts TIMEOUT cycles
    do_reset();
    es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
    ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      mem_dm_req = (i < 5);
      #1;
      chk($sformatf("to_st%0d", i), 32'(state), 32'(es[i]));
      chk($sformatf("to_err%0d", i), 32'(dm_err), 32'(ee[i]));
      tick();
    end
    idle();
    chk("to_stc", 32'(stall_cnt), 32'd5);
    tick();
    tick();
    tick();
    chk("to_sticky", 32'(dm_err), 32'd1);
    do_reset();
    #1;
    chk("to_rstclr", 32'(dm_err), 32'd0);

    // halt deferred behind DM access
    do_reset();
    es = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0};
    ec = '{C_MEM, C_MEM, C_RUN, C_RUN, C_FRZ, C_FRZ, C_FRZ, C_RUN};
    for (int i = 0; i < 8; i++) begin
      halt_req   = (i < 6);
      mem_dm_req = (i < 2);
      dm_ready   = (i == 1);
      #1;
      chk($sformatf("h_st%0d", i), 32'(state), 32'(es[i]));
      chk($sformatf("h_ctl%0d", i), 32'(ctl), 32'(ec[i]));
      tick();
    end
    idle();
    chk("h_stc", 32'(stall_cnt), 32'd5);

    // stall counter saturation
    do_reset();
    halt_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", 32'(stall_cnt), 32'd9);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_top", 32'(stall_cnt), 32'd15);
    chk("sat_st", 32'(state), 32'd3);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the write-enable and clear inputs of the PC register and of the IF_ID, ID_EX, EX_MEM and MEM_WB inter-stage registers. It also runs a small FSM that handshakes multi-cycle data-memory accesses, applies a debug halt, and keeps stall and flush performance counters.

## Interface
- TIMEOUT, 64: maximum MEM_WAIT cycles before a forced release; must be ≥2.
- CW, 16: width of the performance counters.

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load (its ctrl-MEM dmrd bit)
- ex_br_taken  in  1  branch/jump redirect resolved in EX
- mem_dm_req  in  1  MEM instruction accesses DM (dmrd or dmwe)
- dm_ready  in  1  DM access complete
- halt_req  in  1  debug pause request
- pc_wen  out  1  PC write enable
- if_id_wen, if_id_clear  out  1 each  IF_ID controls
- id_ex_wen, id_ex_clear  out  1 each  ID_EX controls
- ex_mem_wen, ex_mem_clear  out  1 each  EX_MEM controls
- mem_wb_wen, mem_wb_clear  out  1 each  MEM_WB controls
- dm_start  out  1  one-cycle DM access launch
- state  out  2  FSM state
- dm_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  CW each  saturating counters

## Operation
- States: RUN=00, MEM_WAIT=01, MEM_DONE=10, HALT=11.
- Transitions:
  - RUN → MEM_WAIT if mem_dm_req.
  - RUN → HALT if halt_req && !mem_dm_req.
  - MEM_WAIT → MEM_DONE on dm_ready, or when the wait counter reaches TIMEOUT-1. A timeout also sets dm_err.
  - MEM_DONE → RUN, unconditionally.
  - HALT → RUN when !halt_req.
- halt_req is ignored outside RUN. dm_ready is ignored outside MEM_WAIT.
- dm_start = (state==RUN && mem_dm_req).
- Load-use hazard: lu = ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Control outputs are combinational. Evaluate in this order; the first matching case applies:
  1. rst: every wen and clear is 0; dm_start is 0.
  2. HALT: every wen and clear is 0 (full freeze).
  3. Memory stall (RUN with mem_dm_req, or MEM_WAIT):
     - pc, if_id, id_ex and ex_mem: wen=0, clear=0.
     - mem_wb: wen=1, clear=1 (bubble into WB).
  4. ex_br_taken (RUN or MEM_DONE):
     - All wen=1.
     - if_id_clear=1 and id_ex_clear=1; other clears 0.
  5. lu:
     - pc_wen=0, if_id_wen=0.
     - id_ex_wen=1 with id_ex_clear=1.
     - ex_mem_wen=1, mem_wb_wen=1; other clears 0.
  6. Otherwise: all wen=1, all clears 0.
- A branch or hazard that coincides with a memory stall is held by the frozen EX_MEM/ID_EX and is applied after release.
- Wait counter: cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle.
- stall_cnt increments on every non-reset cycle with pc_wen==0 (this includes HALT). flush_cnt increments on every case-4 cycle. Both saturate at 2^CW-1.

## Timing
- Reset values: state=RUN, dm_err=0, stall_cnt=0, flush_cnt=0, wait counter=0.
- A reset asserted mid-access aborts it; no dm_start follows until a new RUN evaluation.
- DM access:
  - Cycle 0 (RUN): dm_start=1, stall.
  - Cycle 1 onward (MEM_WAIT): stall.
  - Cycle after dm_ready (MEM_DONE): the pipeline advances.
  - The minimum cost is 2 stall cycles.
- Timeout: MEM_WAIT lasts exactly TIMEOUT cycles, after which MEM_DONE releases the pipeline. dm_err stays set until rst.
- Load-use costs 1 bubble cycle. A taken branch costs 2 squashed instructions.
- Counters update on the clk edge after the qualifying cycle.

## Test plan
- Reset, then idle inputs → state=00, all wen=1, all clears=0, counters 0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1, for 1 cycle → pc_wen=0, if_id_wen=0, id_ex_clear=1, stall_cnt=1. With ex_rd=0 → no stall.
- ex_br_taken=1 together with lu=1 → if_id_clear=1, id_ex_clear=1, pc_wen=1, flush_cnt=1.
- mem_dm_req=1, dm_ready asserted 3 cycles after dm_start:
  - dm_start pulses exactly once.
  - State sequence is 00,01,01,01,10,00.
  - mem_wb_clear=1 throughout the stall.
  - stall_cnt=4.
- TIMEOUT=4, dm_ready never asserted → MEM_WAIT lasts 4 cycles, then MEM_DONE, dm_err=1 sticky. rst clears it.
- halt_req=1 while mem_dm_req=1 → halt deferred until MEM_DONE→RUN, then state=11 with all wen=0. Dropping halt_req → RUN the next cycle.
